// File: rtl/motor_ramp.sv
// Soft-start / direction-change sequencer feeding the four PWM duty inputs.
// Duties slew toward target; a direction change forces ramp-to-zero and a dead-time hold.

module motor_ramp_lane #(
   parameter int STEP = 1
) (
   input  logic [4:0] i_duty,
   input  logic [4:0] i_target,
   output logic [4:0] o_next
);
   localparam logic [5:0] LP_STEP = 6'(STEP);
   logic [5:0] w_gap;

   // Gap is formed from the ordered pair, so it never wraps; short gaps snap to target.
   always_comb begin
      o_next = i_duty;
      w_gap  = 6'd0;
      if (i_duty < i_target) begin
         w_gap  = {1'b0, i_target} - {1'b0, i_duty};
         o_next = (w_gap > LP_STEP) ? 5'(i_duty + LP_STEP[4:0]) : i_target;
      end else if (i_duty > i_target) begin
         w_gap  = {1'b0, i_duty} - {1'b0, i_target};
         o_next = (w_gap > LP_STEP) ? 5'(i_duty - LP_STEP[4:0]) : i_target;
      end
   end
endmodule

module motor_ramp #(
   parameter int RAMP_DIV   = 15,
   parameter int STEP       = 1,
   parameter int DEAD_TICKS = 153
) (
   input  logic       clk_out,
   input  logic       reset,
   input  logic       brake,
   input  logic [3:0] cmd_dir,
   input  logic [4:0] cmd_duty_r,
   input  logic [4:0] cmd_duty_r2,
   input  logic [4:0] cmd_duty_l,
   input  logic [4:0] cmd_duty_l2,
   output logic [4:0] duty_r,
   output logic [4:0] duty_r2,
   output logic [4:0] duty_l,
   output logic [4:0] duty_l2,
   output logic [3:0] dir_out,
   output logic       busy
);
   typedef enum logic [1:0] {RUN, STOPPING, DEAD} state_t;

   state_t            r_state, w_state_nxt;
   logic [3:0][4:0]   r_duty, w_duty_nxt;
   logic [3:0][4:0]   w_cmd, w_target, w_next;
   logic [3:0]        r_dir, w_dir_nxt;
   logic [7:0]        r_presc, w_presc_nxt;
   logic [9:0]        r_dead, w_dead_nxt;
   logic              w_tick, w_all_zero;

   assign w_cmd      = {cmd_duty_r, cmd_duty_r2, cmd_duty_l, cmd_duty_l2};
   assign w_tick     = (r_presc == 8'(RAMP_DIV - 1));
   assign w_all_zero = (r_duty == '0);
   assign w_target   = (r_state == RUN) ? w_cmd : '0;

   for (genvar g = 0; g < 4; g++) begin : g_lane
      motor_ramp_lane #(.STEP(STEP)) u_lane (
         .i_duty  (r_duty[g]),
         .i_target(w_target[g]),
         .o_next  (w_next[g])
      );
   end

   always_ff @(posedge clk_out) begin
      if (reset) begin
         r_state <= RUN;
         r_duty  <= '0;
         r_dir   <= 4'b0000;
         r_presc <= '0;
         r_dead  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_duty  <= w_duty_nxt;
         r_dir   <= w_dir_nxt;
         r_presc <= w_presc_nxt;
         r_dead  <= w_dead_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_duty_nxt  = r_duty;
      w_dir_nxt   = r_dir;
      w_presc_nxt = w_tick ? 8'd0 : r_presc + 8'd1;
      w_dead_nxt  = r_dead;
      if (brake) begin
         w_state_nxt = DEAD;
         w_duty_nxt  = '0;
         w_presc_nxt = '0;
         w_dead_nxt  = '0;
      end else begin
         case (r_state)
            RUN: begin
               // A pending direction change suppresses the step in this cycle.
               if (cmd_dir != r_dir) w_state_nxt = STOPPING;
               else if (w_tick)      w_duty_nxt  = w_next;
            end
            STOPPING: begin
               if (w_all_zero) begin
                  w_state_nxt = DEAD;
                  w_dead_nxt  = '0;
               end else if (w_tick) begin
                  w_duty_nxt = w_next;
               end
            end
            DEAD: begin
               w_duty_nxt  = '0;
               w_presc_nxt = '0;
               w_dead_nxt  = r_dead + 10'd1;
               if (r_dead == 10'(DEAD_TICKS - 1)) begin
                  w_dir_nxt   = cmd_dir;
                  w_state_nxt = RUN;
               end
            end
            default: w_state_nxt = RUN;
         endcase
      end
   end

   assign duty_r  = r_duty[3];
   assign duty_r2 = r_duty[2];
   assign duty_l  = r_duty[1];
   assign duty_l2 = r_duty[0];
   assign dir_out = r_dir;
   assign busy    = (r_state != RUN) || (r_duty != w_cmd);
endmodule

// File: tb/tb_motor_ramp.sv
// Directed bench for motor_ramp: default-parameter unit plus a STEP=4 / RAMP_DIV=1 unit for saturation.
module tb_motor_ramp;
   logic clk_out = 1'b0;
   always #5 clk_out = ~clk_out;

   logic       reset = 1'b1, brake = 1'b0;
   logic [3:0] cmd_dir = 4'b0000;
   logic [4:0] cmd_duty_r = '0, cmd_duty_r2 = '0, cmd_duty_l = '0, cmd_duty_l2 = '0;
   logic [4:0] duty_r, duty_r2, duty_l, duty_l2;
   logic [3:0] dir_out;
   logic       busy;

   logic       s_reset = 1'b1;
   logic [4:0] s_cmd = '0;
   logic [4:0] s_duty_r, s_duty_r2, s_duty_l, s_duty_l2;
   logic [3:0] s_dir_out;
   logic       s_busy;

   int passed = 0, total = 0;
   logic [19:0] all_d;
   assign all_d = {duty_r, duty_r2, duty_l, duty_l2};

   motor_ramp dut (
      .clk_out(clk_out), .reset(reset), .brake(brake), .cmd_dir(cmd_dir),
      .cmd_duty_r(cmd_duty_r), .cmd_duty_r2(cmd_duty_r2),
      .cmd_duty_l(cmd_duty_l), .cmd_duty_l2(cmd_duty_l2),
      .duty_r(duty_r), .duty_r2(duty_r2), .duty_l(duty_l), .duty_l2(duty_l2),
      .dir_out(dir_out), .busy(busy)
   );

   motor_ramp #(.RAMP_DIV(1), .STEP(4), .DEAD_TICKS(3)) dut_sat (
      .clk_out(clk_out), .reset(s_reset), .brake(1'b0), .cmd_dir(4'b0000),
      .cmd_duty_r(s_cmd), .cmd_duty_r2(s_cmd), .cmd_duty_l(s_cmd), .cmd_duty_l2(s_cmd),
      .duty_r(s_duty_r), .duty_r2(s_duty_r2), .duty_l(s_duty_l), .duty_l2(s_duty_l2),
      .dir_out(s_dir_out), .busy(s_busy)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk_out);
      #1;
   endtask

   task automatic set_cmd(input logic [4:0] d);
      cmd_duty_r = d; cmd_duty_r2 = d; cmd_duty_l = d; cmd_duty_l2 = d;
   endtask

   task automatic test_reset;
      reset = 1'b1; tick(2);
      total++; if (all_d !== 20'h0) $display("FAIL reset_duty got=%h exp=0", all_d); else passed++;
      total++; if (dir_out !== 4'b0000) $display("FAIL reset_dir got=%b exp=0000", dir_out); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
   endtask

   task automatic test_ramp_up;
      set_cmd(5'd31); cmd_dir = 4'b0000; reset = 1'b1; tick(1); reset = 1'b0;
      total++; if (busy !== 1'b1) $display("FAIL ramp_busy0 got=%b exp=1", busy); else passed++;
      tick(14);
      total++; if (all_d !== 20'h0) $display("FAIL ramp_e14 got=%h exp=0", all_d); else passed++;
      tick(1);
      total++; if (all_d !== {4{5'd1}}) $display("FAIL ramp_e15 got=%h exp=%h", all_d, {4{5'd1}}); else passed++;
      tick(449);
      total++; if (all_d !== {4{5'd30}}) $display("FAIL ramp_e464 got=%h exp=%h", all_d, {4{5'd30}}); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL ramp_busy464 got=%b exp=1", busy); else passed++;
      tick(1);
      total++; if (all_d !== {4{5'd31}}) $display("FAIL ramp_e465 got=%h exp=%h", all_d, {4{5'd31}}); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL ramp_busy465 got=%b exp=0", busy); else passed++;
      total++; if (dir_out !== 4'b0000) $display("FAIL ramp_dir got=%b exp=0000", dir_out); else passed++;
   endtask

   task automatic test_dir_glitch;
      cmd_dir = 4'b1111; tick(1);
      total++; if (all_d !== {4{5'd31}}) $display("FAIL glitch_hold got=%h exp=%h", all_d, {4{5'd31}}); else passed++;
      cmd_dir = 4'b0000; tick(1);
      total++; if (busy !== 1'b1) $display("FAIL glitch_busy got=%b exp=1", busy); else passed++;
      set_cmd(5'd0); tick(13);
      total++; if (all_d !== {4{5'd30}}) $display("FAIL glitch_step got=%h exp=%h", all_d, {4{5'd30}}); else passed++;
      tick(450);
      total++; if (all_d !== 20'h0) $display("FAIL glitch_zero got=%h exp=0", all_d); else passed++;
      tick(153);
      total++; if (busy !== 1'b1) $display("FAIL glitch_dead_end got=%b exp=1", busy); else passed++;
      tick(1);
      total++; if (busy !== 1'b0) $display("FAIL glitch_run got=%b exp=0", busy); else passed++;
      total++; if (dir_out !== 4'b0000) $display("FAIL glitch_dir got=%b exp=0000", dir_out); else passed++;
      set_cmd(5'd31); tick(465);
      total++; if (all_d !== {4{5'd31}}) $display("FAIL glitch_reramp got=%h exp=%h", all_d, {4{5'd31}}); else passed++;
   endtask

   task automatic test_dir_change;
      cmd_dir = 4'b1010; cmd_duty_r = 5'd0; cmd_duty_r2 = 5'd0; tick(1);
      total++; if (all_d !== {4{5'd31}}) $display("FAIL dc_nostep got=%h exp=%h", all_d, {4{5'd31}}); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL dc_busy got=%b exp=1", busy); else passed++;
      tick(14);
      total++; if (all_d !== {4{5'd30}}) $display("FAIL dc_first got=%h exp=%h", all_d, {4{5'd30}}); else passed++;
      tick(450);
      total++; if (all_d !== 20'h0) $display("FAIL dc_zero got=%h exp=0", all_d); else passed++;
      total++; if (dir_out !== 4'b0000) $display("FAIL dc_dir_early got=%b exp=0000", dir_out); else passed++;
      tick(153);
      total++; if (dir_out !== 4'b0000) $display("FAIL dc_dir_dead got=%b exp=0000", dir_out); else passed++;
      tick(1);
      total++; if (dir_out !== 4'b1010) $display("FAIL dc_dir_new got=%b exp=1010", dir_out); else passed++;
      total++; if (all_d !== 20'h0) $display("FAIL dc_dir_zero got=%h exp=0", all_d); else passed++;
      tick(15);
      total++; if (all_d !== {5'd0, 5'd0, 5'd1, 5'd1}) $display("FAIL dc_l_first got=%h exp=%h", all_d, {5'd0, 5'd0, 5'd1, 5'd1}); else passed++;
      tick(450);
      total++; if (all_d !== {5'd0, 5'd0, 5'd31, 5'd31}) $display("FAIL dc_l_full got=%h exp=%h", all_d, {5'd0, 5'd0, 5'd31, 5'd31}); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL dc_idle got=%b exp=0", busy); else passed++;
   endtask

   task automatic test_brake;
      cmd_duty_r = 5'd31; cmd_duty_r2 = 5'd31; tick(180);
      total++; if (all_d !== {5'd12, 5'd12, 5'd31, 5'd31}) $display("FAIL brk_pre got=%h exp=%h", all_d, {5'd12, 5'd12, 5'd31, 5'd31}); else passed++;
      brake = 1'b1; tick(1);
      total++; if (all_d !== 20'h0) $display("FAIL brk_zero got=%h exp=0", all_d); else passed++;
      total++; if (dir_out !== 4'b1010) $display("FAIL brk_dir got=%b exp=1010", dir_out); else passed++;
      tick(4); brake = 1'b0; set_cmd(5'd0);
      tick(152);
      total++; if (busy !== 1'b1) $display("FAIL brk_dead152 got=%b exp=1", busy); else passed++;
      tick(1);
      total++; if (busy !== 1'b0) $display("FAIL brk_run153 got=%b exp=0", busy); else passed++;
      total++; if (dir_out !== 4'b1010) $display("FAIL brk_dir_exit got=%b exp=1010", dir_out); else passed++;
   endtask

   task automatic test_reset_mid_dead;
      cmd_dir = 4'b0000; tick(12);
      total++; if (busy !== 1'b1) $display("FAIL rst_in_dead got=%b exp=1", busy); else passed++;
      set_cmd(5'd31); reset = 1'b1; tick(1); reset = 1'b0;
      total++; if (all_d !== 20'h0 || dir_out !== 4'b0000) $display("FAIL rst_outs got=%h/%b exp=0/0000", all_d, dir_out); else passed++;
      tick(14);
      total++; if (all_d !== 20'h0) $display("FAIL rst_e14 got=%h exp=0", all_d); else passed++;
      tick(1);
      total++; if (all_d !== {4{5'd1}}) $display("FAIL rst_resume got=%h exp=%h", all_d, {4{5'd1}}); else passed++;
   endtask

   task automatic test_saturation;
      logic [4:0] exp_d;
      s_cmd = 5'd30; s_reset = 1'b1; tick(1); s_reset = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         tick(1);
         exp_d = (4 * k > 30) ? 5'd30 : 5'(4 * k);
         total++; if (s_duty_r !== exp_d || s_duty_l2 !== exp_d) $display("FAIL sat_up%0d got=%0d/%0d exp=%0d", k, s_duty_r, s_duty_l2, exp_d); else passed++;
      end
      s_cmd = 5'd1;
      for (int k = 1; k <= 9; k++) begin
         tick(1);
         exp_d = (30 - 4 * k < 1) ? 5'd1 : 5'(30 - 4 * k);
         total++; if (s_duty_r !== exp_d) $display("FAIL sat_dn%0d got=%0d exp=%0d", k, s_duty_r, exp_d); else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_dir_glitch();
      test_dir_change();
      test_brake();
      test_reset_mid_dead();
      test_saturation();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/motor_ramp.md
# motor_ramp

Soft-start / direction-change sequencer between the car's mode controller and the four PWM generators. It takes the controller's target duty values (0–31) and direction word each clk_out tick, then drives the PWM duty inputs. Duty slews toward target at a bounded rate. Every direction change forces ramp-to-zero, a dead-time hold, and only then the new direction, so the H-bridges never reverse under load.

## Interface
- RAMP_DIV, default 15: clk_out ticks per ramp step (15 ≈ 10 ms at 1525 Hz); legal range 1–255.
- STEP, default 1: duty increment/decrement per ramp step; legal range 1–31.
- DEAD_TICKS, default 153: zero-duty hold before a new direction is applied (≈100 ms); legal range 1–1023.

Ports:
- clk_out  in  1  block clock (divided 1525 Hz clock); reset, synchronous, active-high; clock clk_out.
- reset  in  1  synchronous, active-high.
- brake  in  1  emergency stop; level-sensitive.
- cmd_dir  in  4  requested direction word; bit3 right, bit2 right2, bit1 left, bit0 left2; 1 = reverse.
- cmd_duty_r, cmd_duty_r2, cmd_duty_l, cmd_duty_l2  in  5 each  target duty per channel.
- duty_r, duty_r2, duty_l, duty_l2  out  5 each  registered duty to the PWM generators.
- dir_out  out  4  registered direction word to the bridges.
- busy  out  1  combinational; 1 when state ≠ RUN or any duty ≠ its cmd_duty.

## Operation
- Reset: all duty outputs 0, dir_out 4'b0000, state RUN, prescaler 0, dead counter 0.
- The prescaler counts 0..RAMP_DIV-1 and wraps. A step tick is the cycle in which prescaler == RAMP_DIV-1. The prescaler runs in RUN and STOPPING, is held at 0 in DEAD, and is cleared on DEAD→RUN.
- Step rule, per channel, on a step tick:
  - duty < target: duty = min(duty+STEP, target).
  - duty > target: duty = max(duty−STEP, target).
  - Arithmetic is at least 6 bits wide; there is no wrap and no overshoot.
- States:
  - RUN:
    - target = cmd_duty.
    - If cmd_dir ≠ dir_out, the next state is STOPPING; no step is applied in that cycle.
  - STOPPING:
    - target = 0 for all channels.
    - When all four duties are 0, the next state is DEAD and the dead counter is cleared.
    - The stop always completes, even if cmd_dir returns to dir_out.
  - DEAD:
    - Duties are held at 0; the dead counter increments each cycle.
    - When the counter reaches DEAD_TICKS−1: dir_out = current cmd_dir (latest value, sampled that cycle), and the next state is RUN.
- brake = 1, at the next edge:
  - All duties become 0 immediately (no ramp).
  - State becomes DEAD with the dead counter cleared; it is held cleared while brake = 1.
  - dir_out is unchanged.
  - After brake falls, the full DEAD_TICKS hold elapses before RUN.
- Priority: reset > brake > state logic.
- A cmd_duty change mid-ramp retargets on the next step tick; the direction of slew may reverse freely within RUN.
- If all four duties are already 0 on entry to STOPPING, DEAD follows on the next edge.

## Timing
- All outputs are registered except busy. Duty changes only on edges that are step ticks (or on brake/reset edges).
- Ramp latency from 0 to target T in RUN: ceil(T/STEP) × RAMP_DIV edges after the prescaler start point.
- Direction change latency: STOPPING duration + DEAD_TICKS edges + 1 edge for the RUN→STOPPING transition.
- dir_out and a non-zero duty are never both changed in the same cycle. At the cycle dir_out changes, all duties are 0.

## Test plan
- Ramp up:
  - Stimulus: reset released; cmd_dir = 0000; all cmd_duty = 31; defaults.
  - Required: duty 1 after edge 15; duty 31 after edge 465; busy falls after that edge; dir_out stays 0000.
- Saturation:
  - Stimulus: STEP = 4, RAMP_DIV = 1, target 30 from 0.
  - Required: duty sequence 4, 8, …, 28, 30, 30; never 32 or a wrapped value.
- Direction change:
  - Stimulus: at steady 31/0000, cmd_dir → 1010, cmd_duty_r/r2 → 0.
  - Required: state STOPPING; duties ramp down to 0 (31 steps); 153 edges of DEAD; dir_out = 1010 only after all duties read 0; duty_l/l2 then ramp back to 31.
- Brake mid-ramp:
  - Stimulus: duty at 12, brake = 1 for 5 edges.
  - Required: all duties 0 at the next edge; dir_out unchanged; RUN re-entered exactly 153 edges after brake falls.
- Direction glitch:
  - Stimulus: cmd_dir toggles 0000→1111→0000 within STOPPING.
  - Required: the stop completes; DEAD runs in full; dir_out = 0000 at exit.
- Reset mid-DEAD:
  - Stimulus: reset for 1 edge during DEAD.
  - Required: all outputs 0, state RUN, dir_out 0000, and ramp resumes from 0.
